// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand interface.
//  - NB_DATA_DEF : default byte / operand width
//  - OP_*        : ALU opcodes (MIPS funct encoding, 6 bits)
//  - state_e     : interface FSM state encoding
//  - cnt_width() : counter width needed to reach a terminal count
package alu_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_FUNCT    = 6;

  localparam logic [NB_FUNCT-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_FUNCT-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_FUNCT-1:0] OP_AND = 6'b100100;
  localparam logic [NB_FUNCT-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_FUNCT-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_FUNCT-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_FUNCT-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_FUNCT-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_WAIT_OP1    = 3'd0,
    ST_WAIT_OPCODE = 3'd1,
    ST_WAIT_OP2    = 3'd2,
    ST_WAIT_ALU    = 3'd3,
    ST_SEND        = 3'd4,
    ST_WAIT_TX     = 3'd5
  } state_e;

  // Bits needed to hold values 0..terminal (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal == 0) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/alu_iface_counter.sv
// Clearable up-counter that stops at TERMINAL and flags it.
//  i_clock      : clock
//  i_reset      : asynchronous active-low reset (count -> 0)
//  i_clear      : synchronous load of zero, wins over i_enable
//  i_enable     : count up by one (holds once terminal is reached)
//  o_terminal_c : combinational flag, count == TERMINAL
module alu_iface_counter
  import alu_pkg::*;
#(
  parameter int unsigned TERMINAL = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal_c
);

  localparam int unsigned CNT_W = cnt_width(TERMINAL);

  logic [CNT_W-1:0] r_count;

  assign o_terminal_c = (r_count == CNT_W'(TERMINAL));

  // Saturating count so a late-leaving FSM never sees a wrapped value.
  always_ff @(posedge i_clock or negedge i_reset) begin : p_count
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal_c) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_interface.sv
// Initiator side of the ALU operand protocol between uart_rx/uart_tx and
// the ALU. Loads operand 1, opcode, operand 2 from received bytes, waits the
// ALU latency, then hands the result to the transmitter with a start pulse
// and waits for its done pulse.
// Optional feature: define ALU_IFACE_TIMEOUT_EN to discard a partial frame
// after TIMEOUT_CYCLES idle clocks in WAIT_OPCODE / WAIT_OP2.
//  i_clock      : clock, rising edge
//  i_reset      : asynchronous active-low reset
//  i_rx_data    : received byte, valid with i_rx_done
//  i_rx_done    : 1-cycle pulse, new byte available
//  i_resultado  : ALU result
//  i_tx_done    : 1-cycle pulse, transmitter finished
//  o_operando_1 : ALU operand 1
//  o_operacion  : ALU opcode
//  o_operando_2 : ALU operand 2
//  o_tx_data    : byte to transmit
//  o_tx_start   : 1-cycle pulse, start transmission
module alu_interface
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA        = NB_DATA_DEF,
  parameter int unsigned ALU_LATENCY    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_resultado,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_operando_1,
  output logic [NB_DATA-1:0] o_operacion,
  output logic [NB_DATA-1:0] o_operando_2,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start
);

  state_e             r_state;
  logic [NB_DATA-1:0] r_operando_1;
  logic [NB_DATA-1:0] r_operacion;
  logic [NB_DATA-1:0] r_operando_2;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;

  logic w_in_alu;
  logic w_lat_done;
  logic w_timeout;

  assign o_operando_1 = r_operando_1;
  assign o_operacion  = r_operacion;
  assign o_operando_2 = r_operando_2;
  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = r_tx_start;

  // Latency wait: counter sits at zero outside WAIT_ALU, so it starts
  // clean on the clock after operand 2 is latched.
  assign w_in_alu = (r_state == ST_WAIT_ALU);

  alu_iface_counter #(
    .TERMINAL (ALU_LATENCY)
  ) u_lat_cnt (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (!w_in_alu),
    .i_enable     (w_in_alu),
    .o_terminal_c (w_lat_done)
  );

`ifdef ALU_IFACE_TIMEOUT_EN
  // Idle counter for a partially received frame; any received byte restarts it.
  logic w_mid_frame;
  assign w_mid_frame = (r_state == ST_WAIT_OPCODE) || (r_state == ST_WAIT_OP2);

  alu_iface_counter #(
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_tmo_cnt (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (i_rx_done || !w_mid_frame),
    .i_enable     (w_mid_frame),
    .o_terminal_c (w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign w_timeout            = 1'b0;
`endif

  // Frame sequencing; a received byte in the expiry cycle beats the timeout.
  always_ff @(posedge i_clock or negedge i_reset) begin : p_fsm
    if (!i_reset) begin
      r_state      <= ST_WAIT_OP1;
      r_operando_1 <= '0;
      r_operacion  <= '0;
      r_operando_2 <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_WAIT_OP1: begin
          if (i_rx_done) begin
            r_operando_1 <= i_rx_data;
            r_state      <= ST_WAIT_OPCODE;
          end
        end
        ST_WAIT_OPCODE: begin
          if (i_rx_done) begin
            r_operacion <= i_rx_data;
            r_state     <= ST_WAIT_OP2;
          end else if (w_timeout) begin
            r_state <= ST_WAIT_OP1;
          end
        end
        ST_WAIT_OP2: begin
          if (i_rx_done) begin
            r_operando_2 <= i_rx_data;
            r_state      <= ST_WAIT_ALU;
          end else if (w_timeout) begin
            r_state <= ST_WAIT_OP1;
          end
        end
        ST_WAIT_ALU: begin
          if (w_lat_done) begin
            r_tx_data  <= i_resultado;
            r_tx_start <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          // Any byte arriving here, even with i_tx_done, is dropped.
          if (i_tx_done) begin
            r_state <= ST_WAIT_OP1;
          end
        end
        default: begin
          r_state <= ST_WAIT_OP1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_interface.sv
// Self-checking bench for alu_interface: directed scenarios followed by
// randomized frames, with a queue-based scoreboard checked by a monitor
// whenever o_tx_start is seen. A 2-cycle model ALU supplies i_resultado.
module tb_alu_interface;
  import alu_pkg::*;

  localparam int LAT = 2;
  localparam int TMO = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] resultado;
  logic       tx_done;
  logic [7:0] operando_1;
  logic [7:0] operacion;
  logic [7:0] operando_2;
  logic [7:0] tx_data;
  logic       tx_start;

  alu_interface #(
    .NB_DATA        (8),
    .ALU_LATENCY    (LAT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_resultado  (resultado),
    .i_tx_done    (tx_done),
    .o_operando_1 (operando_1),
    .o_operacion  (operacion),
    .o_operando_2 (operando_2),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_starts = 0;
  int   n_expected = 0;
  bit   prev_start = 1'b0;

  // Reference model state: frame phase 0/1/2 = expecting op1/opcode/op2, 3 = busy.
  logic [7:0] m_op1, m_op, m_op2, m_tx, m_hold;
  int         m_phase;
  logic [7:0] known_ops [8];
  logic [7:0] alu_s1 = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_known(input logic [7:0] op);
    case (op)
      8'(OP_ADD), 8'(OP_SUB), 8'(OP_AND), 8'(OP_OR),
      8'(OP_XOR), 8'(OP_SRA), 8'(OP_SRL), 8'(OP_NOR): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] op,
                                       input logic [7:0] b);
    case (op)
      8'(OP_ADD): return a + b;
      8'(OP_SUB): return a - b;
      8'(OP_AND): return a & b;
      8'(OP_OR):  return a | b;
      8'(OP_XOR): return a ^ b;
      8'(OP_SRA): return 8'($signed(a) >>> b);
      8'(OP_SRL): return a >> b;
      8'(OP_NOR): return ~(a | b);
      default:    return 8'h00;
    endcase
  endfunction

  // Environment ALU: two-register pipeline, holds on unknown opcodes.
  always @(posedge clk) begin
    if (is_known(operacion)) alu_s1 <= alu_f(operando_1, operacion, operando_2);
    resultado <= alu_s1;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every start pulse pops one expected result.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      n_starts++;
      check_int("start_single_cycle", int'(prev_start), 0);
      if (exp_q.size() == 0) begin
        check_int("unexpected_start", n_starts, n_expected);
      end else begin
        mon_e = exp_q.pop_front();
        check8("tx_data", tx_data, mon_e.data);
        check_int("tx_latency", cyc, mon_e.cyc);
      end
    end
    prev_start = (tx_start === 1'b1);
  end

  task automatic model_reset();
    m_op1 = 8'h00; m_op = 8'h00; m_op2 = 8'h00; m_tx = 8'h00;
    m_phase = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int s);
    case (m_phase)
      0: begin m_op1 = b; m_phase = 1; end
      1: begin m_op  = b; m_phase = 2; end
      2: begin m_op2 = b; m_phase = 3; end
      default: return;
    endcase
    if (is_known(m_op)) m_hold = alu_f(m_op1, m_op, m_op2);
    if (m_phase == 3) begin
      m_tx = m_hold;
      exp_q.push_back('{data: m_hold, cyc: s + LAT + 1});
      n_expected++;
    end
  endtask

  task automatic check_ops(input string tag);
    check8({tag, "_op1"}, operando_1, m_op1);
    check8({tag, "_opc"}, operacion, m_op);
    check8({tag, "_op2"}, operando_2, m_op2);
  endtask

  task automatic check_reset_state(input string tag);
    check_ops(tag);
    check8({tag, "_txd"}, tx_data, 8'h00);
    check_int({tag, "_txs"}, int'(tx_start), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_tx);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1; tx_done = with_tx;
    @(posedge clk); #1;
    rx_done = 1'b0; tx_done = 1'b0;
    if (with_tx && m_phase == 3) m_phase = 0;
    else model_byte(b, cyc);
    check_ops("byte");
  endtask

  task automatic send_tx_done();
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    if (m_phase == 3) m_phase = 0;
  endtask

  task automatic wait_start();
    for (int k = 0; k < 20 && n_starts < n_expected; k++) begin
      @(negedge clk); #1;
    end
    check_int("start_seen", n_starts, n_expected);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    known_ops = '{8'(OP_ADD), 8'(OP_SUB), 8'(OP_AND), 8'(OP_OR),
                  8'(OP_XOR), 8'(OP_SRA), 8'(OP_SRL), 8'(OP_NOR)};
    m_hold = 8'h00;
    model_reset();
    rst_n = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset after operand 1 clears everything at once.
    send_byte(8'h11, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("midframe_reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic ADD, then a byte dropped while waiting for tx_done.
    send_byte(8'h05, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h03, 1'b0);
    wait_start();
    send_byte(8'hAA, 1'b0);
    send_tx_done();
    send_byte(8'h0F, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h01, 1'b0);
    wait_start();

    // rx and tx done together in WAIT_TX: exit only, byte dropped.
    send_byte(8'h99, 1'b1);

    // Stray tx_done while waiting for the opcode.
    send_byte(8'h30, 1'b0);
    send_tx_done();
    send_byte(8'h26, 1'b0); send_byte(8'h0F, 1'b0);
    wait_start();
    send_tx_done();

    // Reset during the start pulse drops o_tx_start immediately.
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
    wait_start();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("midtx_reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Partial frame left idle for TMO clocks.
    send_byte(8'h07, 1'b0);
    idle(TMO);
`ifdef ALU_IFACE_TIMEOUT_EN
    m_phase = 0;
`endif
    send_byte(8'h02, 1'b0); send_byte(8'h24, 1'b0); send_byte(8'h03, 1'b0);
    wait_start();
    send_tx_done();

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 3; i++) begin
        idle(int'($urandom_range(0, 4)));
        if (i == 1 && $urandom_range(0, 4) == 0) send_tx_done();
        if (i == 1 && $urandom_range(0, 9) != 0) b = known_ops[3'($urandom_range(0, 7))];
        else b = 8'($urandom_range(0, 255));
        send_byte(b, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0);
      wait_start();
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 255)), 1'b1);
      else send_tx_done();
      check8("tx_data_hold", tx_data, m_tx);
    end

    idle(5);
    check_int("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
